// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the FSM state encoding and the iteration counter sizing.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One shift-subtract-restore step of a restoring unsigned divider.
// Purely combinational; the caller owns all state.
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] q_next
);

   logic [2*WIDTH:0] sh;
   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   t;

   assign sh   = {a, q} << 1;
   assign a_sh = sh[2*WIDTH:WIDTH];
   assign t    = a_sh - {1'b0, m};

   // A negative trial difference restores the shifted partial remainder.
   always_comb begin
      a_next = a_sh;
      q_next = sh[WIDTH-1:0];
      if (!t[WIDTH]) begin
         a_next    = t;
         q_next[0] = 1'b1;
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Start/busy/done handshake with abort and divide-by-zero shortcut.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   import seq_div_pkg::*;

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_next;
   logic             last;
   logic             zero;

   div_step #(.WIDTH(WIDTH)) u_step (
      .a      (a),
      .q      (q),
      .m      (m),
      .a_next (a_next),
      .q_next (q_next)
   );

   assign last = (count == CNT_W'(WIDTH - 1));
   assign zero = (divisor == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  m           <= divisor;
                  q           <= dividend;
                  a           <= '0;
                  count       <= '0;
                  div_by_zero <= zero;
                  // A zero divisor skips iteration and reports at once.
                  if (zero) begin
                     state     <= DONE;
                     quotient  <= '1;
                     remainder <= dividend;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else begin
                  a     <= a_next;
                  q     <= q_next;
                  count <= count + CNT_W'(1);
                  if (last) begin
                     quotient  <= q_next;
                     remainder <= a_next[WIDTH-1:0];
                     state     <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: latency, handshake, abort,
// reset and an exhaustive quotient/remainder sweep at WIDTH=4.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic         abort;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   typedef struct {
      int dd;
      int dv;
      int q;
      int r;
      int dz;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   last_q = 0;
   int   last_r = 0;
   int   last_dz = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Every done pulse retires the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("quotient", int'(quotient), mon_e.q);
            check_eq("remainder", int'(remainder), mon_e.r);
            check_eq("div_by_zero", int'(div_by_zero), mon_e.dz);
            if (mon_e.dv != 0) begin
               check_eq("invariant",
                        int'(quotient) * mon_e.dv + int'(remainder),
                        mon_e.dd);
               check_eq("rem_lt_div",
                        int'(int'(remainder) < mon_e.dv), 1);
            end
            last_q  = mon_e.q;
            last_r  = mon_e.r;
            last_dz = mon_e.dz;
         end
      end
   end

   task automatic start_op(input int dd, input int dv);
      exp_t e;
      e.dd = dd;
      e.dv = dv;
      e.q  = (dv == 0) ? (1 << W) - 1 : dd / dv;
      e.r  = (dv == 0) ? dd : dd % dv;
      e.dz = (dv == 0) ? 1 : 0;
      sb.push_back(e);
      start    = 1'b1;
      dividend = W'(dd);
      divisor  = W'(dv);
   endtask

   // Called at the first negedge after the accepting edge.
   task automatic wait_done(input int exp_lat, input bit noise);
      int cyc = 0;
      int bc  = 0;
      while (!done && cyc < 40) begin
         if (busy) bc++;
         if (noise) begin
            start = (cyc == 1);
            if (cyc == 1) begin
               dividend = W'($urandom_range(0, 15));
               divisor  = W'($urandom_range(1, 15));
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_eq("latency", cyc, exp_lat);
      check_eq("busy_cycles", bc, (exp_lat == 0) ? 0 : W);
   endtask

   task automatic finish_done();
      @(negedge clk);
      check_eq("done_pulse", int'(done), 0);
   endtask

   task automatic do_div(input int dd, input int dv, input bit noise);
      start_op(dd, dv);
      @(negedge clk);
      start = 1'b0;
      wait_done((dv == 0) ? 0 : W, noise);
      finish_done();
   endtask

   initial begin
      int nd;
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_q", int'(quotient), 0);
      check_eq("rst_r", int'(remainder), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_dz", int'(div_by_zero), 0);
      rst = 1'b0;
      @(negedge clk);

      do_div(13, 3, 0);
      do_div(7, 0, 0);

      start_op(6, 2);
      @(negedge clk);
      start = 1'b0;
      check_eq("dz_clear", int'(div_by_zero), 0);
      check_eq("accept_busy", int'(busy), 1);
      wait_done(W, 0);
      finish_done();

      do_div(15, 1, 0);
      do_div(2, 9, 0);
      do_div(15, 15, 0);
      do_div(0, 5, 0);

      start_op(13, 3);
      @(negedge clk);
      start = 1'b0;
      wait_done(W, 0);
      start_op(9, 4);
      @(negedge clk);
      start = 1'b0;
      check_eq("b2b_busy", int'(busy), 1);
      check_eq("b2b_done", int'(done), 0);
      wait_done(W, 0);
      finish_done();

      do_div(10, 3, 1);

      start_op(11, 2);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_busy", int'(busy), 0);
      check_eq("abort_q", int'(quotient), last_q);
      check_eq("abort_r", int'(remainder), last_r);
      check_eq("abort_dz", int'(div_by_zero), last_dz);
      nd = 0;
      repeat (6) begin
         if (done) nd++;
         @(negedge clk);
      end
      check_eq("abort_nodone", nd, 0);

      abort = 1'b1;
      start_op(14, 3);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      wait_done(W, 0);
      finish_done();

      start_op(15, 2);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      check_eq("mrst_q", int'(quotient), 0);
      check_eq("mrst_r", int'(remainder), 0);
      check_eq("mrst_busy", int'(busy), 0);
      check_eq("mrst_done", int'(done), 0);
      check_eq("mrst_dz", int'(div_by_zero), 0);
      @(negedge clk);

      for (int dd = 0; dd < 16; dd++) begin
         for (int dv = 1; dv < 16; dv++) begin
            do_div(dd, dv, 0);
         end
      end

      check_eq("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
